// File: rtl/sword_attack_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : sword_attack_renderer_if
// Description : Sword sprite ROM / palette bus. The renderer (master) drives
//               the ROM address and frame select; the ROM/palette side
//               (slave) returns the registered palette index and its
//               combinational colour.
// Revision    : 1.0 - initial release
// ============================================================================
interface sword_attack_renderer_if;
    logic [9:0] rom_address;
    logic [1:0] rom_sel;
    logic [2:0] rom_q;
    logic [3:0] pal_red;
    logic [3:0] pal_green;
    logic [3:0] pal_blue;

    modport master (
        output rom_address,
        output rom_sel,
        input  rom_q,
        input  pal_red,
        input  pal_green,
        input  pal_blue
    );

    modport slave (
        input  rom_address,
        input  rom_sel,
        output rom_q,
        output pal_red,
        output pal_green,
        output pal_blue
    );
endinterface
`default_nettype wire

// File: rtl/sword_attack_renderer.sv
`default_nettype none
// ============================================================================
// Module      : sword_attack_renderer
// Description : Sequences the sword-swing animation, places the sword sprite
//               beside Link, drives the sprite ROM address/frame select and
//               composites palette colour over the background with the ROM's
//               one-cycle read latency. RGB is registered (2-clock latency).
// Revision    : 1.0 - initial release
// ============================================================================
module sword_attack_renderer #(
    parameter int SPR_SIZE        = 32,
    parameter int SWORD_DX        = 16,
    parameter int FRAME_HOLD      = 4,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic        vga_clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        frame_start,
    input  logic        attack,
    input  logic [9:0]  link_x,
    input  logic [9:0]  link_y,
    input  logic [3:0]  bg_red,
    input  logic [3:0]  bg_green,
    input  logic [3:0]  bg_blue,
    sword_attack_renderer_if.master rom,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        busy
);

    localparam int              c_AW        = $clog2(SPR_SIZE);
    localparam int              c_CW        = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(FRAME_HOLD - 1);
    localparam logic [10:0]     c_SPR       = 11'(SPR_SIZE);
    localparam logic [10:0]     c_DX        = 11'(SWORD_DX);
    localparam logic [2:0]      c_TRANSP    = 3'(TRANSPARENT_IDX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SWING1  = 2'd1,
        S_SWING2  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_atk_q;
    logic [1:0]        r_rom_sel;
    logic              r_busy;
    logic [10:0]       r_sx;
    logic [10:0]       r_sy;
    logic              r_hit_d;
    logic              r_blank_d;
    logic [11:0]       r_bg_d;

    logic              w_edge;
    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic              w_hit;
    logic [2*c_AW-1:0] w_addr_cat;

    // Stage 0: offsets from the latched origin. Negative offsets wrap to large
    // unsigned values, so a single unsigned compare rejects both sides.
    assign w_edge     = attack & ~r_atk_q;
    assign w_dx       = {1'b0, DrawX} - r_sx;
    assign w_dy       = {1'b0, DrawY} - r_sy;
    assign w_hit      = (r_state != S_IDLE) && (w_dx < c_SPR) && (w_dy < c_SPR);
    assign w_addr_cat = {w_dy[c_AW-1:0], w_dx[c_AW-1:0]};

    assign rom.rom_address = (w_hit && !Reset) ? 10'(w_addr_cat) : 10'd0;
    assign rom.rom_sel     = r_rom_sel;
    assign busy            = r_busy;

    // Sprite origin is only re-latched at frame start so it never tears.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_sx <= 11'd0;
            r_sy <= 11'd0;
        end else if (frame_start) begin
            r_sx <= {1'b0, link_x} + c_DX;
            r_sy <= {1'b0, link_y};
        end
    end

    // Swing sequencer: each animation step is held for FRAME_HOLD frames.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_atk_q   <= 1'b0;
            r_rom_sel <= 2'd0;
            r_busy    <= 1'b0;
        end else begin
            r_atk_q <= attack;
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_state   <= S_SWING1;
                        r_cnt     <= '0;
                        r_rom_sel <= 2'd1;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    if (frame_start) begin
                        if (r_cnt == c_HOLD_LAST) begin
                            r_cnt <= '0;
                            case (r_state)
                                S_SWING1: begin
                                    r_state   <= S_SWING2;
                                    r_rom_sel <= 2'd2;
                                end
                                S_SWING2: begin
                                    r_state   <= S_RECOVER;
                                    r_rom_sel <= 2'd1;
                                end
                                default: begin
                                    r_state   <= S_IDLE;
                                    r_rom_sel <= 2'd0;
                                    r_busy    <= 1'b0;
                                end
                            endcase
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Stage 1: delay hit/blank/background to line up with rom_q.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_hit_d   <= 1'b0;
            r_blank_d <= 1'b0;
            r_bg_d    <= 12'd0;
        end else begin
            r_hit_d   <= w_hit;
            r_blank_d <= blank;
            r_bg_d    <= {bg_red, bg_green, bg_blue};
        end
    end

    // Output register: blanking wins, then opaque sprite, then background.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            {red, green, blue} <= 12'd0;
        end else if (!r_blank_d) begin
            {red, green, blue} <= 12'd0;
        end else if (r_hit_d && (rom.rom_q != c_TRANSP)) begin
            {red, green, blue} <= {rom.pal_red, rom.pal_green, rom.pal_blue};
        end else begin
            {red, green, blue} <= r_bg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sword_attack_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sword_attack_renderer
// Description : Self-checking bench for sword_attack_renderer. Plays the
//               sprite ROM/palette and compares every cycle against a
//               frame-counting reference model of the swing and the pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sword_attack_renderer;

    localparam int SPR_SIZE        = 32;
    localparam int SWORD_DX        = 16;
    localparam int FRAME_HOLD      = 4;
    localparam int TRANSPARENT_IDX = 0;

    logic       vga_clk     = 1'b0;
    logic       Reset       = 1'b1;
    logic [9:0] DrawX       = '0;
    logic [9:0] DrawY       = '0;
    logic       blank       = 1'b0;
    logic       frame_start = 1'b0;
    logic       attack      = 1'b0;
    logic [9:0] link_x      = '0;
    logic [9:0] link_y      = '0;
    logic [3:0] bg_red      = '0;
    logic [3:0] bg_green    = '0;
    logic [3:0] bg_blue     = '0;
    logic [3:0] red, green, blue;
    logic       busy;

    sword_attack_renderer_if rif();

    sword_attack_renderer #(
        .SPR_SIZE        (SPR_SIZE),
        .SWORD_DX        (SWORD_DX),
        .FRAME_HOLD      (FRAME_HOLD),
        .TRANSPARENT_IDX (TRANSPARENT_IDX)
    ) dut (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_start (frame_start),
        .attack      (attack),
        .link_x      (link_x),
        .link_y      (link_y),
        .bg_red      (bg_red),
        .bg_green    (bg_green),
        .bg_blue     (bg_blue),
        .rom         (rif.master),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    // Sprite ROMs (upper half = sword_right_2) and palette played by the bench.
    logic [2:0]  rom_mem [0:2047];
    logic [11:0] pal_tab [0:7];

    always @(posedge vga_clk) rif.rom_q <= rom_mem[{rif.rom_sel[1], rif.rom_address}];
    assign rif.pal_red   = pal_tab[rif.rom_q][11:8];
    assign rif.pal_green = pal_tab[rif.rom_q][7:4];
    assign rif.pal_blue  = pal_tab[rif.rom_q][3:0];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: swing tracked as frame_starts elapsed since it began.
    int          m_sx     = 0;
    int          m_sy     = 0;
    bit          m_busy   = 1'b0;
    int          m_frames = 0;
    bit          m_atk    = 1'b0;
    logic [11:0] m_rgb    = '0;
    logic [11:0] m_stage  = '0;
    bit          started  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One pixel clock: compare, then advance the model across the edge.
    task automatic step();
        int          dx, dy, addr, sel;
        bit          hit, rise;
        logic [2:0]  idx;
        logic [10:0] ri;
        logic [11:0] pix;
        #1;
        sel  = !m_busy ? 0 : (((m_frames / FRAME_HOLD) == 1) ? 2 : 1);
        dx   = int'(DrawX) - m_sx;
        dy   = int'(DrawY) - m_sy;
        hit  = m_busy && dx >= 0 && dx < SPR_SIZE && dy >= 0 && dy < SPR_SIZE;
        addr = (hit && !Reset) ? dy * SPR_SIZE + dx : 0;
        if (started) begin
            check("rgb", {red, green, blue}, m_rgb);
            check("rom_sel", rif.rom_sel, sel);
            check("busy", busy, m_busy);
            check("rom_address", rif.rom_address, addr);
        end
        ri  = {(sel == 2), 10'(addr)};
        idx = rom_mem[ri];
        if (!blank)                             pix = 12'h000;
        else if (hit && idx != TRANSPARENT_IDX) pix = pal_tab[idx];
        else                                    pix = {bg_red, bg_green, bg_blue};
        if (Reset) begin
            m_rgb = '0; m_stage = '0; m_sx = 0; m_sy = 0;
            m_busy = 1'b0; m_frames = 0; m_atk = 1'b0; started = 1'b1;
        end else begin
            m_rgb   = m_stage;
            m_stage = pix;
            rise    = attack && !m_atk;
            m_atk   = attack;
            if (!m_busy) begin
                if (rise) begin m_busy = 1'b1; m_frames = 0; end
            end else if (frame_start) begin
                m_frames++;
                if (m_frames == 3 * FRAME_HOLD) m_busy = 1'b0;
            end
            if (frame_start) begin
                m_sx = int'(link_x) + SWORD_DX;
                m_sy = int'(link_y);
            end
        end
        @(negedge vga_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        for (int i = 0; i < 8; i++) pal_tab[i] = 12'($urandom);
        rom_mem[65]        = 3'd2;
        rom_mem[1024 + 65] = 3'd0;
        pal_tab[2]         = 12'hFF0;

        @(negedge vga_clk);
        #1;
        Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;

        // Idle: background passes through, no sprite.
        {bg_red, bg_green, bg_blue} = 12'h357;
        blank = 1'b1; link_x = 10'd100; link_y = 10'd200;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            DrawX = 10'(114 + i); DrawY = 10'd202; step();
        end

        // Swing with a probe pixel inside the sprite and a repeated attack.
        attack = 1'b1; step(); attack = 1'b0;
        DrawX = 10'd117; DrawY = 10'd202; step();
        check("addr65", rif.rom_address, 32'd65);
        for (int f = 0; f < 3 * FRAME_HOLD; f++) begin
            frame_start = 1'b1; step(); frame_start = 1'b0;
            attack = (f == 2); step();
            attack = 1'b0;
            repeat (2) step();
        end
        check("swing_done", busy, 32'd0);

        // Right edge: coincident attack/frame_start, no wrap to column 0.
        link_x = 10'd620; link_y = 10'd100;
        frame_start = 1'b1; attack = 1'b1; step();
        frame_start = 1'b0; attack = 1'b0;
        DrawX = 10'd639; DrawY = 10'd100; step();
        check("edge_addr3", rif.rom_address, 32'd3);
        DrawX = 10'd0; step();
        check("no_wrap", rif.rom_address, 32'd0);

        // Mid-frame move and blanking, then reset mid-swing.
        link_x = 10'd300; DrawX = 10'd639; blank = 1'b0; repeat (3) step();
        blank = 1'b1;
        Reset = 1'b1; repeat (3) step();
        Reset = 1'b0;
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_sel", rif.rom_sel, 32'd0);
        check("rst_rgb", {red, green, blue}, 32'd0);
        check("rst_addr", rif.rom_address, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            Reset       = ($urandom_range(0, 799) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) attack = ~attack;
            blank = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 63) == 0) begin
                link_x = 10'($urandom_range(0, 1023));
                link_y = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 3) == 0) DrawX = 10'($urandom);
            else DrawX = 10'(m_sx + int'($urandom_range(0, 40)) - 4);
            if ($urandom_range(0, 3) == 0) DrawY = 10'($urandom);
            else DrawY = 10'(m_sy + int'($urandom_range(0, 40)) - 4);
            {bg_red, bg_green, bg_blue} = 12'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
